// File: rtl/ram_axil_arbiter.sv
// rtl/ram_axil_arbiter.sv - two-requester round-robin arbiter driving one AXI4-Lite master port
module ram_axil_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            req0_valid,
  input  logic                            req0_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_wdata,
  output logic                            req0_ready,
  output logic                            req0_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   req0_rdata,
  output logic [1:0]                      req0_resp,
  input  logic                            req1_valid,
  input  logic                            req1_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_wdata,
  output logic                            req1_ready,
  output logic                            req1_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   req1_rdata,
  output logic [1:0]                      req1_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t                          state, state_next;
  logic                            last_grant, owner;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   cap_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   cap_wdata;
  logic                            aw_valid, w_valid;

  logic                            grant, grant_sel, sel_we;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   sel_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   sel_wdata;
  logic                            fin;
  logic [1:0]                      fin_resp;
  logic [C_M_AXI_DATA_WIDTH-1:0]   fin_data;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    // On a tie the requester that did not win last time gets the bus.
    grant_sel  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    sel_we     = grant_sel ? req1_we    : req0_we;
    sel_addr   = grant_sel ? req1_addr  : req0_addr;
    sel_wdata  = grant_sel ? req1_wdata : req0_wdata;
    fin        = 1'b0;
    fin_resp   = 2'b00;
    fin_data   = '0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant      = 1'b1;
          state_next = sel_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (!(aw_valid && !M_AXI_AWREADY) && !(w_valid && !M_AXI_WREADY))
          state_next = WR_RESP;
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          fin        = 1'b1;
          fin_resp   = M_AXI_BRESP;
          state_next = IDLE;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY)
          state_next = RD_DATA;
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          fin        = 1'b1;
          fin_resp   = M_AXI_RRESP;
          fin_data   = M_AXI_RDATA;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      req0_resp  <= 2'b00;
      req1_resp  <= 2'b00;
    end else begin
      state     <= state_next;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      if (grant) begin
        owner      <= grant_sel;
        last_grant <= grant_sel;
        cap_addr   <= sel_addr;
        cap_wdata  <= sel_wdata;
        aw_valid   <= sel_we;
        w_valid    <= sel_we;
      end
      if (aw_valid && M_AXI_AWREADY) aw_valid <= 1'b0;
      if (w_valid && M_AXI_WREADY)   w_valid  <= 1'b0;
      if (fin) begin
        if (owner) begin
          req1_done  <= 1'b1;
          req1_rdata <= fin_data;
          req1_resp  <= fin_resp;
        end else begin
          req0_done  <= 1'b1;
          req0_rdata <= fin_data;
          req0_resp  <= fin_resp;
        end
      end
    end
  end

  assign req0_ready    = grant && !grant_sel;
  assign req1_ready    = grant && grant_sel;
  assign M_AXI_AWADDR  = cap_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_valid;
  assign M_AXI_WDATA   = cap_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_BREADY  = (state == WR_RESP);
  assign M_AXI_ARADDR  = cap_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state == RD_ADDR);
  assign M_AXI_RREADY  = (state == RD_DATA);

endmodule

// File: tb/tb_ram_axil_arbiter.sv
// tb/tb_ram_axil_arbiter.sv - scoreboard bench for ram_axil_arbiter with a 4-register AXI4-Lite slave model
module tb_ram_axil_arbiter;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req0_done, req1_ready, req1_done;
  logic [31:0] req0_rdata, req1_rdata;
  logic [1:0]  req0_resp, req1_resp;
  logic [3:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  ram_axil_arbiter #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: AWREADY after aw_delay waiting cycles, W/AR immediate, B/R one cycle later.
  logic [31:0] mem [4];
  int          aw_delay = 0;
  int          aw_cnt;
  logic        got_aw, got_w, hold_b = 1'b0;
  logic [3:0]  sv_awaddr;
  logic [31:0] sv_wdata;
  logic [1:0]  rerr = 2'b00;
  logic        aw_hs, w_hs;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  assign AWREADY = AWVALID && (aw_cnt >= aw_delay);
  assign WREADY  = WVALID;
  assign ARREADY = ARVALID;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign wr_addr = got_aw ? sv_awaddr : AWADDR;
  assign wr_data = got_w ? sv_wdata : WDATA;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; sv_awaddr <= '0; sv_wdata <= '0;
      BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) aw_cnt <= 0;
      else if (AWVALID) aw_cnt <= aw_cnt + 1;
      if (aw_hs) begin got_aw <= 1'b1; sv_awaddr <= AWADDR; end
      if (w_hs)  begin got_w <= 1'b1;  sv_wdata <= WDATA;   end
      if ((got_aw || aw_hs) && (got_w || w_hs) && !BVALID && !hold_b) begin
        mem[wr_addr[3:2]] <= wr_data;
        BVALID <= 1'b1; BRESP <= 2'b00; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1; RDATA <= mem[ARADDR[3:2]]; RRESP <= rerr;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  typedef struct {logic [31:0] rdata; logic [1:0] resp;} exp_t;
  exp_t        q0[$], q1[$];
  int          grant_log[$];
  int          rdy0_cnt = 0, done0_cnt = 0;
  int          last_acc_cyc = 0, last_done_cyc = 0, bvalid_cyc = -1;
  int          aw_hi = 0, w_hi = 0;
  logic [3:0]  last_awaddr = '0, prev_awaddr = '0;
  logic [31:0] last_wdata = '0;
  logic        aw_waiting = 1'b0;

  always @(negedge ACLK) begin
    exp_t e;
    if (ARESET) begin
      aw_waiting = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        grant_log.push_back(req1_ready ? 1 : 0);
        last_acc_cyc = cyc;
        if (req0_ready) rdy0_cnt++;
      end
      if (req0_done) begin
        done0_cnt++;
        last_done_cyc = cyc;
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done0: got done, expected none");
        end else begin
          e = q0.pop_front();
          check("rdata0", req0_rdata, e.rdata);
          check("resp0", {30'd0, req0_resp}, {30'd0, e.resp});
        end
      end
      if (req1_done) begin
        last_done_cyc = cyc;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done1: got done, expected none");
        end else begin
          e = q1.pop_front();
          check("rdata1", req1_rdata, e.rdata);
          check("resp1", {30'd0, req1_resp}, {30'd0, e.resp});
        end
      end
      if (AWVALID || WVALID)
        check("aw_w_exclusive", {29'd0, ARVALID, RREADY, BREADY}, 32'd0);
      if (WVALID) check("wstrb", {28'd0, WSTRB}, 32'hF);
      if (AWVALID) check("awprot", {29'd0, AWPROT}, 32'd0);
      if (ARVALID) check("arprot", {29'd0, ARPROT}, 32'd0);
      if (AWVALID && aw_waiting) check("awaddr_stable", {28'd0, AWADDR}, {28'd0, prev_awaddr});
      aw_waiting  = AWVALID && !AWREADY;
      prev_awaddr = AWADDR;
      if (aw_hs) last_awaddr = AWADDR;
      if (w_hs)  last_wdata = WDATA;
      if (AWVALID) aw_hi++;
      if (WVALID)  w_hi++;
      if (BVALID && bvalid_cyc < 0) bvalid_cyc = cyc;
    end
  end

  // Called and returns just after a rising edge; leaves valid low afterwards.
  task automatic issue(input int n, input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [31:0] erd, input logic [1:0] eresp);
    exp_t e;
    int   t;
    logic rdy;
    e.rdata = erd;
    e.resp  = eresp;
    if (n == 0) begin
      q0.push_back(e);
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      q1.push_back(e);
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
    t = 0;
    forever begin
      @(negedge ACLK); #1;
      rdy = (n == 0) ? req0_ready : req1_ready;
      if (rdy) break;
      t++;
      if (t > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: requester %0d got no ready, expected ready", n);
        break;
      end
    end
    @(posedge ACLK); #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
      @(negedge ACLK); #1;
      t++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
      q0.delete(); q1.delete();
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int d0, r0;
    int exp_g [4];
    exp_g = '{0, 1, 0, 1};
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    check("rst_valids", {27'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    check("rst_done", {30'd0, req0_done, req1_done}, 32'd0);
    check("rst_rdata0", req0_rdata, 32'd0);
    check("rst_resp1", {30'd0, req1_resp}, 32'd0);

    // Zero-wait write from requester 0.
    issue(0, 1'b1, 4'h0, 32'h1, 32'h0, 2'b00);
    drain();
    check("wr_latency", last_done_cyc - last_acc_cyc, 32'd3);
    check("wr_awaddr", {28'd0, last_awaddr}, 32'h0);
    check("wr_wdata", last_wdata, 32'h1);

    // Requester 1 write then read, requester 0 idle.
    r0 = rdy0_cnt; d0 = done0_cnt;
    issue(1, 1'b1, 4'h4, 32'hA5A50002, 32'h0, 2'b00);
    issue(1, 1'b0, 4'h4, 32'h0, 32'hA5A50002, 2'b00);
    drain();
    check("rd_latency", last_done_cyc - last_acc_cyc, 32'd3);
    check("no_req0_ready", rdy0_cnt - r0, 32'd0);
    check("no_req0_done", done0_cnt - d0, 32'd0);

    // Slave error response is forwarded once, never retried.
    rerr = 2'b10; d0 = done0_cnt;
    issue(0, 1'b0, 4'h0, 32'h0, 32'h1, 2'b10);
    drain();
    rerr = 2'b00;
    repeat (5) @(posedge ACLK);
    #1;
    check("err_done_once", done0_cnt - d0, 32'd1);
    check("err_idle", {30'd0, ARVALID, RREADY}, 32'd0);

    // AWREADY held off 5 cycles, WREADY immediate.
    aw_delay = 5; aw_hi = 0; w_hi = 0; bvalid_cyc = -1;
    issue(1, 1'b1, 4'h8, 32'h55, 32'h0, 2'b00);
    drain();
    aw_delay = 0;
    check("bp_aw_cycles", aw_hi, 32'd6);
    check("bp_w_cycles", w_hi, 32'd1);
    check("bp_done_after_b", last_done_cyc - bvalid_cyc, 32'd1);

    // Reset while waiting in WR_RESP abandons the write without done.
    hold_b = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'hC; req0_wdata = 32'h7;
    d0 = 0;
    while (d0 < 20) begin
      @(negedge ACLK); #1;
      if (req0_ready) break;
      d0++;
    end
    @(posedge ACLK); #1;
    req0_valid = 1'b0;
    d0 = 0;
    while (!BREADY && d0 < 20) begin
      @(negedge ACLK); #1;
      d0++;
    end
    check("rst_mid_in_wr_resp", {31'd0, BREADY}, 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("rst_mid_valids", {27'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    check("rst_mid_done", {30'd0, req0_done, req1_done}, 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0; hold_b = 1'b0;

    // Both requesters held after reset: grants alternate starting at 0.
    grant_log.delete();
    fork
      begin
        issue(0, 1'b1, 4'h8, 32'h3, 32'h0, 2'b00);
        issue(0, 1'b1, 4'h8, 32'h3, 32'h0, 2'b00);
      end
      begin
        issue(1, 1'b1, 4'hC, 32'h4, 32'h0, 2'b00);
        issue(1, 1'b1, 4'hC, 32'h4, 32'h0, 2'b00);
      end
    join
    drain();
    check("rr_grants", grant_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("rr_grant_%0d", i), grant_log[i], exp_g[i]);
    issue(0, 1'b0, 4'h8, 32'h0, 32'h3, 2'b00);
    issue(1, 1'b0, 4'hC, 32'h0, 32'h4, 2'b00);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_axil_arbiter.md
# ram_axil_arbiter

Two-port round-robin arbiter and AXI4-Lite master that shares the Ram_IP AXI4-Lite slave port (4 x 32-bit registers) between two local requesters. It converts single-word read and write requests into complete AXI4-Lite transactions, one at a time, and returns read data and the response code to the granted requester. It sits between the fabric-side clients and the Ram_IP S00_AXI port, on the same clock as the IP.

## Interface
- C_M_AXI_ADDR_WIDTH, 4, byte-address width toward Ram_IP.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESET  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request from requester N (N = 0, 1); held until reqN_ready.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  C_M_AXI_ADDR_WIDTH  byte address, passed through unmodified.
- reqN_wdata  in  32  write data.
- reqN_ready  out  1  one-cycle accept pulse; request fields are captured on this cycle.
- reqN_done  out  1  one-cycle completion pulse.
- reqN_rdata  out  32  read data, valid with reqN_done; 0 for writes.
- reqN_resp  out  2  BRESP or RRESP, valid with reqN_done.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channel signals.

## Operation
- FSM states: IDLE, WR (AW and W outstanding), WR_RESP, RD_ADDR, RD_DATA.
- IDLE, no valid requests: stay in IDLE.
- IDLE, one valid request: grant it. reqN_ready is asserted combinationally in this cycle. Capture we, addr and wdata, and record last_grant = N.
- IDLE, both requests valid: grant the requester that is not last_grant.
- last_grant resets to 1, so requester 0 wins the first tie.
- Grant with we = 1: go to WR. Grant with we = 0: go to RD_ADDR.
- WR:
  - AWVALID and WVALID are asserted from the first WR cycle.
  - Each one drops independently on the cycle after its own handshake (VALID and READY both high).
  - Leave WR for WR_RESP once both handshakes have completed; they may complete in the same cycle or in either order.
- WR_RESP: BREADY = 1. On BVALID, register BRESP, pulse done, go to IDLE.
- RD_ADDR: ARVALID = 1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, register RDATA and RRESP, pulse done, go to IDLE.
- Fixed outputs: WSTRB = 4'hF, AWPROT = ARPROT = 3'b000.
- AWADDR, ARADDR and WDATA come from the captured registers and stay stable while the corresponding VALID is high.
- Error responses (SLVERR/DECERR) are forwarded unchanged in reqN_resp. They are never retried.
- A non-granted request stays pending. Its reqN_ready remains 0 until it is granted.
- Arithmetic: none beyond capture and pass-through. Address wrap and alignment are the requester's responsibility.

## Timing
- Reset values: state = IDLE; last_grant = 1; all VALID, BREADY, RREADY, reqN_ready and reqN_done = 0; rdata = 0; resp = 0; captured registers = 0.
- Reset mid-transaction: on the first clock edge with ARESET high, all channel VALIDs and READYs drop. The transaction is abandoned and no done pulse is issued. Ram_IP shares this reset.
- Accept at cycle T (reqN_ready high). AW, W and AR VALID rise at T+1.
- Minimum write latency, with zero-wait slave, AWREADY = WREADY = 1 at T+1, and BVALID at T+2: done at T+3.
- Minimum read latency, with ARREADY at T+1 and RVALID at T+2: done at T+3.
- reqN_done is registered. In the done cycle the FSM is already in IDLE and may accept the next request (done and ready in the same cycle).
- Back-to-back throughput with a zero-wait slave: one transaction per 3 cycles.
- At most one outstanding AXI transaction at any time. The AW/W and AR channels are never active together.
- At most one reqN_ready per cycle across both requesters.

## Test plan
- Write, requester 0, zero-wait: addr 0x0, wdata 0x00000001 -> AWADDR = 0x0, WDATA = 1, WSTRB = F; req0_done at T+3 with resp = 0, rdata = 0.
- Write then read, requester 1: write 0x4 = 0xA5A5_0002, then read 0x4 -> req1_rdata = 0xA5A50002, resp = 0; no req0 activity.
- Simultaneous requests after reset, both held continuously: req0 write 0x8 = 3, req1 write 0xC = 4 -> grants alternate 0, 1, 0, 1. Each requester gets exactly one grant per two transactions. Final read-back gives 0x8 = 3 and 0xC = 4.
- Backpressure: AWREADY delayed 5 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID holds for 6 cycles with a stable address, BREADY rises only after both handshakes, done 1 cycle after BVALID.
- Error path: slave returns RRESP = 2'b10 on a read of 0x0 -> req0_resp = 2, req0_done pulses once, no retry, FSM returns to IDLE.
- Reset mid-write: assert ARESET while in WR_RESP -> next cycle all VALIDs, BREADY and done = 0 and state = IDLE. After release, a simultaneous request grants requester 0 first.
